router_fsm: RTL
===============

Name: router_fsm

Overview:
Control FSM for the 1x3 packet router. It sits upstream of the three per-port output FIFOs and the input register/parity block. It decodes the header address and sequences header, payload and parity loading. It stalls on FIFO full and aborts on a per-port soft reset. All outputs are Moore decodes of the current state.

Parameters:
None. Port count is fixed at 3; address field is data_in[1:0]; address 2'b11 is invalid.

Ports:
clock  in  1  system clock, all state changes on posedge
resetn  in  1  synchronous, active-low reset
pkt_valid  in  1  high during header and payload bytes, low on the parity byte
data_in  in  2  header address bits, meaningful in DECODE_ADDRESS
fifo_full  in  1  full flag of the currently addressed FIFO (muxed by synchronizer)
fifo_empty_0/1/2  in  1 each  per-port FIFO empty flags
soft_reset_0/1/2  in  1 each  per-port soft reset (read timeout)
parity_done  in  1  parity byte captured by register block
low_packet_valid  in  1  pkt_valid fell while FIFO was full
detect_add  out  1  state==DECODE_ADDRESS
lfd_state  out  1  state==LOAD_FIRST_DATA (header write, drives FIFO lfd_state)
ld_state  out  1  state==LOAD_DATA
laf_state  out  1  state==LOAD_AFTER_FULL
full_state  out  1  state==FIFO_FULL_STATE
write_enb_reg  out  1  state in {LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL}
rst_int_reg  out  1  state==CHECK_PARITY_ERROR
busy  out  1  high in every state except DECODE_ADDRESS and LOAD_DATA

Behaviour:
- 8 states, 3-bit encoding: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
- Reset (resetn=0 at posedge): state=DECODE_ADDRESS, addr_q=2'b00. After reset, detect_add=1 and all other outputs are 0.
- addr_q latches data_in on any cycle in DECODE_ADDRESS with pkt_valid=1 and data_in!=3. It holds in all other states.
- Soft reset: if soft_reset_n is 1 for n==addr_q and state!=DECODE_ADDRESS, the next state is DECODE_ADDRESS. This has priority over all other transitions. Soft resets of other ports are ignored.
- DECODE_ADDRESS:
  - pkt_valid and addr n (0..2) with fifo_empty_n=1 -> LOAD_FIRST_DATA.
  - pkt_valid and addr n with fifo_empty_n=0 -> WAIT_TILL_EMPTY.
  - addr 3 or pkt_valid=0 -> stay.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally (1 cycle).
- LOAD_DATA:
  - fifo_full -> FIFO_FULL_STATE.
  - Otherwise pkt_valid=0 -> LOAD_PARITY.
  - Otherwise stay.
- FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL, else stay.
- LOAD_AFTER_FULL:
  - parity_done -> DECODE_ADDRESS.
  - Otherwise low_packet_valid -> LOAD_PARITY.
  - Otherwise -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else DECODE_ADDRESS.
- WAIT_TILL_EMPTY: fifo_empty_{addr_q}=1 -> LOAD_FIRST_DATA, else stay.
- Minimum packet cost: header 1 cycle, N payload cycles in LOAD_DATA, then LOAD_PARITY and CHECK_PARITY_ERROR (2 cycles). busy therefore rises 1 cycle after pkt_valid falls.
- Unreachable encodings fall to DECODE_ADDRESS.
- Outputs are purely combinational from the state register: no glitches from inputs and zero extra latency.

Decomposition:
- Shared router package holds:
  - the state enumeration and encodings;
  - ADDR_INVALID = 2'b11;
  - NUM_PORTS = 3.
- No sub-module. The design is a single two-process FSM (state register plus next-state/output logic) with an addr_q register. The per-port empty and soft-reset select is an inline mux on addr_q.

Test Plan:
- Reset then pkt_valid=1, data_in=2'b01, fifo_empty_1=1 -> next cycle lfd_state=1, busy=1. Following cycle ld_state=1, write_enb_reg=1, busy=0.
- 3-byte payload, then pkt_valid=0 -> LOAD_PARITY (write_enb_reg=1, busy=1), then CHECK_PARITY_ERROR (rst_int_reg=1), then detect_add=1.
- fifo_full=1 in LOAD_DATA -> full_state=1, held 4 cycles. fifo_full=0 -> laf_state=1. Then parity_done=0, low_packet_valid=1 -> LOAD_PARITY.
- Header to addr 2 with fifo_empty_2=0 -> WAIT_TILL_EMPTY, busy=1 for 5 cycles. fifo_empty_2=1 -> lfd_state=1.
- Mid-payload, addr_q=0: soft_reset_1=1 -> no effect. soft_reset_0=1 -> detect_add=1 next cycle.
- Header with data_in=2'b11 and pkt_valid=1 -> remains DECODE_ADDRESS, no write enables. resetn=0 during FIFO_FULL_STATE -> detect_add=1, full_state=0 next cycle.

Source files
------------

// File: rtl/router_fsm_pkg.sv
// Shared definitions for the 1x3 packet router control FSM.
// Holds the state enumeration, port/address constants and the
// per-port flag select helper used by the FSM.
package router_fsm_pkg;

  localparam int unsigned NUM_PORTS = 3;
  localparam int unsigned ADDR_W    = 2;
  localparam int unsigned STATE_W   = 3;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_e;

  // Select the flag of one port; the invalid address selects nothing.
  function automatic logic port_sel(input logic [ADDR_W-1:0]    addr,
                                    input logic [NUM_PORTS-1:0] flags);
    logic sel;
    sel = 1'b0;
    case (addr)
      2'd0:    sel = flags[0];
      2'd1:    sel = flags[1];
      2'd2:    sel = flags[2];
      default: sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 packet router.
// Decodes the header address, sequences header/payload/parity loading,
// stalls while the addressed FIFO is full and aborts on that port's
// soft reset. Outputs are Moore decodes of the state register.
//
// Ports:
//   clock, resetn                 clock and synchronous active-low reset
//   pkt_valid                     high on header/payload, low on parity
//   data_in[1:0]                  header address (used in DECODE_ADDRESS)
//   fifo_full                     full flag of the addressed FIFO
//   fifo_empty_0/1/2              per-port FIFO empty flags
//   soft_reset_0/1/2              per-port soft reset (read timeout)
//   parity_done                   parity byte captured
//   low_packet_valid              pkt_valid fell while FIFO was full
//   detect_add .. busy            state decodes (see bodies below)
module router_fsm
  import router_fsm_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_packet_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy
);

  state_e              r_state;
  state_e              w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                w_addr_load;
  logic [NUM_PORTS-1:0] w_empty_vec;
  logic [NUM_PORTS-1:0] w_srst_vec;
  logic                w_hdr_valid;
  logic                w_hdr_empty;
  logic                w_addr_empty;
  logic                w_addr_srst;

  assign w_empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign w_srst_vec  = {soft_reset_2, soft_reset_1, soft_reset_0};

  // State and latched destination address.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= DECODE_ADDRESS;
      r_addr  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_addr_load) begin
        r_addr <= data_in;
      end
    end
  end

  // Next-state logic and Moore output decodes.
  always_comb begin
    w_hdr_valid   = pkt_valid && (data_in != ADDR_INVALID);
    w_hdr_empty   = port_sel(data_in, w_empty_vec);
    w_addr_empty  = port_sel(r_addr, w_empty_vec);
    w_addr_srst   = port_sel(r_addr, w_srst_vec);
    w_addr_load   = (r_state == DECODE_ADDRESS) && w_hdr_valid;
    w_next_state  = r_state;

    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b1;

    case (r_state)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
        busy       = 1'b0;
        if (w_hdr_valid) begin
          w_next_state = w_hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: begin
        lfd_state    = 1'b1;
        w_next_state = LOAD_DATA;
      end
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
        if (fifo_full) begin
          w_next_state = FIFO_FULL_STATE;
        end else if (!pkt_valid) begin
          w_next_state = LOAD_PARITY;
        end
      end
      FIFO_FULL_STATE: begin
        full_state = 1'b1;
        if (!fifo_full) begin
          w_next_state = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
        if (parity_done) begin
          w_next_state = DECODE_ADDRESS;
        end else if (low_packet_valid) begin
          w_next_state = LOAD_PARITY;
        end else begin
          w_next_state = LOAD_DATA;
        end
      end
      LOAD_PARITY: begin
        write_enb_reg = 1'b1;
        w_next_state  = CHECK_PARITY_ERROR;
      end
      CHECK_PARITY_ERROR: begin
        rst_int_reg  = 1'b1;
        w_next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (w_addr_empty) begin
          w_next_state = LOAD_FIRST_DATA;
        end
      end
      default: begin
        w_next_state = DECODE_ADDRESS;
      end
    endcase

    // A soft reset of the port being served abandons the packet.
    if ((r_state != DECODE_ADDRESS) && w_addr_srst) begin
      w_next_state = DECODE_ADDRESS;
    end
  end

endmodule
